truth_table_sweeper: RTL
========================

// Module: truth_table_sweeper
// PURPOSE
//   Sequencer that exhaustively exercises a combinational boolean function block
//   (x, y, z -> s style). It drives every input combination in ascending order
//   and samples the function output after a programmable settle time.
//   It builds the minterm mask and compares it to an expected mask.
//   Sits between a test/control host and the fxy-style function instance under check.
// PARAMETERS
//   N_IN    3   number of function inputs; mask width is 2**N_IN
//   SETTLE  1   cycles each vector is held before f_in is sampled (>=1)
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          async reset, active low
//   start      in   1          sweep request; sampled only in IDLE
//   abort      in   1          sync abort; return to IDLE, no done
//   expected   in   2**N_IN    golden minterm mask, latched on start accept
//   vec_out    out  N_IN       drives function inputs; msb=x, lsb=z for N_IN=3
//   f_in       in   1          function output s from the block under check
//   busy       out  1          high from start accept until done cycle
//   done       out  1          1-cycle pulse; result outputs are valid in that cycle
//   mask       out  2**N_IN    mask[i] = f_in sampled while vec_out==i
//   mismatch   out  1          mask != latched expected; valid from done until next start
//   first_err  out  N_IN       lowest index i with mask[i]!=expected[i]; 0 if none
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE
//     - vec_out, busy, done, mask, mismatch, first_err, idx, cnt all 0
//   FSM: IDLE -> RUN -> DONE -> IDLE
//   IDLE:
//     - vec_out=0
//     - On start=1 and abort=0 at edge E0: latch expected, clear mask,
//       idx=0, cnt=SETTLE-1, busy<=1, go RUN.
//   RUN (vec_out==idx):
//     - If cnt!=0, decrement cnt.
//     - If cnt==0: mask[idx]<=f_in.
//     - Then, if idx==2**N_IN-1, go DONE; otherwise idx++ and cnt=SETTLE-1.
//     - Vector i is driven during cycles E0+i*SETTLE .. E0+(i+1)*SETTLE-1.
//     - Vector i is sampled at edge E0+(i+1)*SETTLE.
//   DONE entry (edge E0+2**N_IN*SETTLE):
//     - done<=1, busy<=0, vec_out<=0.
//     - mismatch and first_err are computed from the final mask (incl. last sample).
//     - Next edge: done<=0, go IDLE.
//     - start is ignored during the DONE cycle.
//   Result hold: mask, mismatch and first_err hold until the next accepted start,
//     which clears mask, mismatch and first_err.
//   Abort:
//     - abort=1 in RUN or DONE -> IDLE at next edge.
//     - Clears busy, done, mask, mismatch, first_err and idx; vec_out<=0.
//     - abort=1 with start=1 in IDLE: abort wins, start ignored.
//   start while busy: ignored; no restart, no error.
//   Reset mid-sweep: immediate return to reset values; no done pulse.
//   Widths:
//     - idx is N_IN bits; the compare to all-ones ends the sweep, so there is no wrap.
//     - cnt is $clog2(SETTLE)+1 bits.
// TESTING
//   1. f_in = vec_out[2]|vec_out[1] (x+y), expected=8'hFC, SETTLE=1, start @E0
//      -> done in cycle after E0+8; mask=8'hFC; mismatch=0; first_err=0.
//   2. Same function, expected=8'hFE
//      -> mask=8'hFC, mismatch=1, first_err=1.
//   3. SETTLE=3
//      -> each vector held 3 cycles; done after E0+24; vec_out returns to 0 at done.
//   4. start pulsed again mid-sweep at idx=4
//      -> ignored; sweep completes; done pulses exactly once.
//   5. abort asserted at idx=5
//      -> next cycle IDLE, busy=0, mask=0, no done.
//      rst_n dropped at idx=3 -> outputs 0 immediately.
//   6. start and abort both high in IDLE
//      -> stays IDLE, busy stays 0.
//      Back-to-back: start held high through DONE -> new sweep begins the cycle after done.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input vector of a combinational function in
// ascending order, samples its output after a programmable settle time, builds the
// minterm mask and compares it against a golden mask latched at start.
module truth_table_sweeper #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(2**N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        vec_out,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   done,
    output logic [(2**N_IN)-1:0]   mask,
    output logic                   mismatch,
    output logic [N_IN-1:0]        first_err
);

    localparam int unsigned NV = 2**N_IN;
    localparam int unsigned CW = $clog2(SETTLE) + 1;
    localparam logic [N_IN-1:0] IdxMax = {N_IN{1'b1}};
    localparam logic [CW-1:0] CntReload = CW'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NV-1:0]     exp_q, exp_d;
    logic [NV-1:0]     mask_q, mask_d;
    logic              mismatch_q, mismatch_d;
    logic [N_IN-1:0]   first_err_q, first_err_d;

    logic [NV-1:0]     mask_sampled;
    logic [N_IN-1:0]   err_idx;
    logic              err_found;

    // Mask including the sample taken this cycle, and its lowest differing bit,
    // so the result flags at DONE entry already account for the last vector.
    always_comb begin
        mask_sampled         = mask_q;
        mask_sampled[idx_q]  = f_in;
        err_idx              = '0;
        err_found            = 1'b0;
        for (int unsigned i = 0; i < NV; i++) begin
            if ((mask_sampled[i] != exp_q[i]) && !err_found) begin
                err_idx   = N_IN'(i);
                err_found = 1'b1;
            end
        end
    end

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        mask_d      = mask_q;
        mismatch_d  = mismatch_q;
        first_err_d = first_err_q;
        unique case (state_q)
            StIdle: begin
                // abort has priority over start
                if (start && !abort) begin
                    exp_d       = expected;
                    mask_d      = '0;
                    mismatch_d  = 1'b0;
                    first_err_d = '0;
                    idx_d       = '0;
                    cnt_d       = CntReload;
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d     = StIdle;
                    idx_d       = '0;
                    mask_d      = '0;
                    mismatch_d  = 1'b0;
                    first_err_d = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    mask_d = mask_sampled;
                    if (idx_q == IdxMax) begin
                        state_d     = StDone;
                        mismatch_d  = err_found;
                        first_err_d = err_idx;
                    end else begin
                        idx_d = idx_q + N_IN'(1);
                        cnt_d = CntReload;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (abort) begin
                    idx_d       = '0;
                    mask_d      = '0;
                    mismatch_d  = 1'b0;
                    first_err_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            mask_q      <= '0;
            mismatch_q  <= 1'b0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            mask_q      <= mask_d;
            mismatch_q  <= mismatch_d;
            first_err_q <= first_err_d;
        end
    end

    // Outputs are decoded straight from registered state, so vec_out drops to 0 in DONE.
    always_comb begin
        vec_out   = (state_q == StRun) ? idx_q : '0;
        busy      = (state_q == StRun);
        done      = (state_q == StDone);
        mask      = mask_q;
        mismatch  = mismatch_q;
        first_err = first_err_q;
    end

endmodule
